risk_datapath: RTL and testbench
================================

Name: risk_datapath

Overview:
Execution datapath of the multi-cycle RV32I-subset core: combinational instruction decoder, 32x32 register file, and registered ALU in one block. The core controller supplies the fetched instruction word, PC and rden/wren strobes, and sequences FETCH -> DECODE -> EXECUTE -> WRITE_BACK. The block returns decode results and the jump-target operands the controller needs for PC update.

Parameters:
XLEN, 32, datapath and register width.
NREGS, 32, architectural register count; register 0 is hardwired to zero.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
insn  in  32  instruction word; the controller holds it stable from the rden cycle through the wren cycle
pc  in  32  PC of insn, used for the JAL/JALR link value
rden  in  1  register-read strobe
wren  in  1  register-write strobe
opcode  out  5  insn[6:2]
invalid  out  1  unsupported instruction
rd  out  5  destination register index
imm  out  32  decoded immediate
rs1_val  out  32  registered rs1 read value (JALR base)
alu_out  out  32  registered ALU result

Behaviour:
- Decode is combinational from insn. Fields: rd=insn[11:7], funct3=insn[14:12], rs1=insn[19:15], rs2=insn[24:20].
- Supported opcodes: OP 01100, OP-IMM 00100, LUI 01101, JAL 11011, JALR 11001.
- invalid=1 when insn[1:0]!=11, on any other opcode, or on an illegal funct7 (anything other than 0000000 for OP, and 0100000 only on ADD/SRx; for OP-IMM, bad funct7 on shifts). When invalid, register writes are suppressed.
- Immediates, all sign-extended:
  - I-type for OP-IMM and JALR: insn[31:20].
  - U-type for LUI: {insn[31:12], 12'b0}.
  - J-type for JAL: {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
  - OP: imm=0.
- alu_op (4 bits) = {b5, funct3}:
  - b5=insn[30] for OP, and for OP-IMM funct3=101 only; otherwise b5=0.
  - LUI/JAL/JALR use ADD (0000).
  - Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Any other code gives result 0.
- ALU operands:
  - A = rs1 read register, or 0 for LUI.
  - B = imm for OP-IMM and LUI, otherwise rs2 read register.
  - Shifts use B[4:0]. SLT is signed; SLTU is unsigned. Result 1/0 zero-extended. Wrap-around on add/sub overflow, no flags.
- Register file: 32 flops of XLEN bits.
  - Read: on a rising edge with rden=1, both rs1 and rs2 values are captured into read registers. The read registers hold otherwise.
  - Write: on a rising edge with wren=1, rd!=0 and !invalid, reg[rd] <= wb_data.
  - Write data: wb_data = pc+4 when opcode is JAL/JALR, else alu_out.
  - Register 0 always reads 0.
  - A read and a write on the same edge to the same register return the old value (no bypass).
- Latency:
  - Read registers are valid 1 edge after rden.
  - alu_out updates every edge from the current read registers, so it is valid 2 edges after rden.
  - The controller asserts wren no earlier than the cycle in which alu_out is valid.
- Reset (rst=0, asynchronous): all 32 registers, both read registers and alu_out clear to 0. Decode outputs are combinational and unaffected. Reset mid-operation discards any pending write.

Optional Feature:
Macro DATAPATH_TRACE_EN.
- Defined: simulation-only $display on every committed register write, format "x<rd> <= <hex value>", and on every rden edge where invalid=1, with the insn value.
- Undefined: no display statements; logic is identical.

Decomposition:
- Package risk_pkg holds:
  - opcode localparams: OPC_OP, OPC_OPIMM, OPC_LUI, OPC_JAL, OPC_JALR;
  - the alu_op enum typedef alu_op_t;
  - XLEN.
- One sub-module, dp_regfile: 32x32 storage, registered dual read, x0 handling. Decode and ALU stay inline in risk_datapath.

Test Plan:
- Reset, then rden on "addi x1,x0,5" (0x00500093), ALU settle, wren, then read x1 -> x1=5. Then "add x2,x1,x1" -> x2=10. Then "sub x3,x0,x1" -> x3=0xFFFFFFFB.
- "lui x4,0x12345" -> x4=0x12345000. "addi x0,x0,7" followed by reading x0 -> x0 reads 0.
- x5=0x80000000: "srai x6,x5,4" -> 0xF8000000; "srli" -> 0x08000000; "slt x7,x5,x0" -> 1; "sltu" -> 0.
- pc=0x100, "jal x1,+8" (0x008000EF) -> imm=8, x1=0x104. "jalr x2,4(x1)" -> rs1_val=0x104, imm=4, x2=pc+4.
- insn=0xFFFFFFFF or opcode 00000 -> invalid=1, and wren leaves the register file unchanged. Assert rst low while wren is high -> all registers and alu_out read 0 after release.

Source files
------------

// File: rtl/risk_pkg.sv
// ============================================================================
// Module   : risk_pkg
// Brief    : Shared opcode constants, ALU operation encoding and datapath width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package risk_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OPC_OP    = 5'b01100;
    localparam logic [4:0] OPC_OPIMM = 5'b00100;
    localparam logic [4:0] OPC_LUI   = 5'b01101;
    localparam logic [4:0] OPC_JAL   = 5'b11011;
    localparam logic [4:0] OPC_JALR  = 5'b11001;

    // Encoding is {b5, funct3}; codes outside this set produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/dp_regfile.sv
// ============================================================================
// Module   : dp_regfile
// Brief    : Architectural register file with registered dual read; x0 reads 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_regfile #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rden_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic            wren_i,
    input  logic [AW-1:0]   rd_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] rs2_val_q;

    // Reads sample the pre-edge contents, so a same-edge write is not bypassed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            if (rden_i) begin
                rs1_val_q <= (rs1_i == '0) ? '0 : regs_q[rs1_i];
                rs2_val_q <= (rs2_i == '0) ? '0 : regs_q[rs2_i];
            end
            if (wren_i && (rd_i != '0)) begin
                regs_q[rd_i] <= wdata_i;
            end
        end
    end

    assign rs1_val_o = rs1_val_q;
    assign rs2_val_o = rs2_val_q;

endmodule

`default_nettype wire

// File: rtl/risk_datapath.sv
// ============================================================================
// Module   : risk_datapath
// Brief    : RV32I-subset execute datapath: decoder, register file, registered ALU.
// Config   : DATAPATH_TRACE_EN enables simulation trace of writes and invalid reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risk_datapath
    import risk_pkg::*;
#(
    parameter int XLEN  = risk_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     insn_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            rden_i,
    input  logic            wren_i,
    output logic [4:0]      opcode_o,
    output logic            invalid_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] alu_out_o
);

    logic [4:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_invalid;
    logic            w_b5;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic [XLEN-1:0] w_wb_data;
    logic            w_is_jump;
    logic            w_we;
    logic [XLEN-1:0] alu_out_q;

    assign w_opcode = insn_i[6:2];
    assign w_funct3 = insn_i[14:12];
    assign w_funct7 = insn_i[31:25];

    always_comb begin
        w_invalid = (insn_i[1:0] != 2'b11);
        w_imm     = '0;
        w_b5      = 1'b0;
        w_alu_op  = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                w_b5     = insn_i[30];
                w_alu_op = {w_b5, w_funct3};
                // funct7=0100000 is only meaningful for SUB and SRA.
                if (!((w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))) begin
                    w_invalid = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_imm = {{(XLEN-11){insn_i[31]}}, insn_i[30:20]};
                if (w_funct3 == 3'b101) begin
                    w_b5 = insn_i[30];
                    if ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000)) begin
                        w_invalid = 1'b1;
                    end
                end
                if ((w_funct3 == 3'b001) && (w_funct7 != 7'b0000000)) begin
                    w_invalid = 1'b1;
                end
                w_alu_op = {w_b5, w_funct3};
            end
            OPC_LUI: begin
                w_imm = {{(XLEN-31){insn_i[31]}}, insn_i[30:12], 12'b0};
            end
            OPC_JAL: begin
                w_imm = {{(XLEN-20){insn_i[31]}}, insn_i[19:12], insn_i[20],
                         insn_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_imm = {{(XLEN-11){insn_i[31]}}, insn_i[30:20]};
            end
            default: begin
                w_invalid = 1'b1;
            end
        endcase
    end

    assign w_op_a  = (w_opcode == OPC_LUI) ? '0 : w_rs1_val;
    assign w_op_b  = ((w_opcode == OPC_OPIMM) || (w_opcode == OPC_LUI)) ? w_imm : w_rs2_val;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            ALU_SLL:  w_alu_res = w_op_a << w_shamt;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            default:  w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= w_alu_res;
        end
    end

    assign w_is_jump = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);
    assign w_wb_data = w_is_jump ? (pc_i + XLEN'(4)) : alu_out_q;
    assign w_we      = wren_i && !w_invalid;

    dp_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rden_i    (rden_i),
        .rs1_i     (insn_i[19:15]),
        .rs2_i     (insn_i[24:20]),
        .wren_i    (w_we),
        .rd_i      (insn_i[11:7]),
        .wdata_i   (w_wb_data),
        .rs1_val_o (w_rs1_val),
        .rs2_val_o (w_rs2_val)
    );

`ifdef DATAPATH_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (w_we && (insn_i[11:7] != 5'd0)) begin
                $display("x%0d <= %h", insn_i[11:7], w_wb_data);
            end
            if (rden_i && w_invalid) begin
                $display("invalid insn %h", insn_i);
            end
        end
    end
`endif

    assign opcode_o  = w_opcode;
    assign invalid_o = w_invalid;
    assign rd_o      = insn_i[11:7];
    assign imm_o     = w_imm;
    assign rs1_val_o = w_rs1_val;
    assign alu_out_o = alu_out_q;

endmodule

`default_nettype wire

// File: tb/tb_risk_datapath.sv
// ============================================================================
// Module   : tb_risk_datapath
// Brief    : Scoreboard bench for risk_datapath using directed instruction vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risk_datapath;

    localparam int S_ALU = 0;
    localparam int S_RS1 = 1;
    localparam int S_IMM = 2;
    localparam int S_INV = 3;
    localparam int S_OPC = 4;
    localparam int S_RD  = 5;

    logic        clk    = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] insn   = 32'h0;
    logic [31:0] pc     = 32'h0;
    logic        rden   = 1'b0;
    logic        wren   = 1'b0;
    logic [4:0]  opcode;
    logic        invalid;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] alu_out;

    always #5 clk = ~clk;

    risk_datapath #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .insn_i    (insn),
        .pc_i      (pc),
        .rden_i    (rden),
        .wren_i    (wren),
        .opcode_o  (opcode),
        .invalid_o (invalid),
        .rd_o      (rd),
        .imm_o     (imm),
        .rs1_val_o (rs1_val),
        .alu_out_o (alu_out)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q [$];
    int          total   = 0;
    int          bad     = 0;
    logic        chk_stb = 1'b0;
    exp_t        mon_e;
    logic [31:0] mon_act;

    // Monitor: pops one expectation per strobe and compares the selected output.
    always @(negedge clk) begin
        if (chk_stb) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got strobe required queued expectation");
            end else begin
                mon_e = sb_q.pop_front();
                case (mon_e.sel)
                    S_ALU:   mon_act = alu_out;
                    S_RS1:   mon_act = rs1_val;
                    S_IMM:   mon_act = imm;
                    S_INV:   mon_act = {31'b0, invalid};
                    S_OPC:   mon_act = {27'b0, opcode};
                    default: mon_act = {27'b0, rd};
                endcase
                total++;
                if (mon_act !== mon_e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h required %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
        chk_stb = 1'b1;
        @(negedge clk);
        #1 chk_stb = 1'b0;
    endtask

    // rden edge, ALU settle edge, then write-back edge; insn is held afterwards.
    task automatic exec(input logic [31:0] i_word, input logic [31:0] i_pc);
        insn = i_word;
        pc   = i_pc;
        rden = 1'b1;
        @(posedge clk);
        #1 rden = 1'b0;
        @(posedge clk);
        #1 wren = 1'b1;
        @(posedge clk);
        #1 wren = 1'b0;
    endtask

    task automatic rdreg(input logic [4:0] r, input logic [31:0] exp, input string name);
        insn = {12'd0, r, 3'b000, 5'd0, 7'b0110011};
        pc   = 32'h0;
        rden = 1'b1;
        @(posedge clk);
        #1 rden = 1'b0;
        expect_val(name, S_RS1, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_alu", S_ALU, 32'h0);
        expect_val("rst_rs1", S_RS1, 32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        exec(32'h00500093, 32'h0);                       // addi x1,x0,5
        expect_val("addi_imm", S_IMM, 32'h5);
        expect_val("addi_alu", S_ALU, 32'h5);
        rdreg(5'd1, 32'h5, "x1_addi");

        exec(32'h00108133, 32'h0);                       // add x2,x1,x1
        expect_val("add_opc", S_OPC, 32'h0C);
        expect_val("add_rd",  S_RD,  32'h2);
        expect_val("add_inv", S_INV, 32'h0);
        rdreg(5'd2, 32'hA, "x2_add");

        exec(32'h401001B3, 32'h0);                       // sub x3,x0,x1
        expect_val("sub_alu", S_ALU, 32'hFFFFFFFB);
        rdreg(5'd3, 32'hFFFFFFFB, "x3_sub");

        exec(32'h12345237, 32'h0);                       // lui x4,0x12345
        expect_val("lui_imm", S_IMM, 32'h12345000);
        rdreg(5'd4, 32'h12345000, "x4_lui");

        exec(32'h00700013, 32'h0);                       // addi x0,x0,7
        rdreg(5'd0, 32'h0, "x0_zero");

        exec(32'hFFF00613, 32'h0);                       // addi x12,x0,-1
        rdreg(5'd12, 32'hFFFFFFFF, "x12_neg");

        exec(32'h800002B7, 32'h0);                       // lui x5,0x80000
        rdreg(5'd5, 32'h80000000, "x5_lui");
        exec(32'h4042D313, 32'h0);                       // srai x6,x5,4
        rdreg(5'd6, 32'hF8000000, "x6_srai");
        exec(32'h0042D313, 32'h0);                       // srli x6,x5,4
        rdreg(5'd6, 32'h08000000, "x6_srli");
        exec(32'h0002A3B3, 32'h0);                       // slt x7,x5,x0
        rdreg(5'd7, 32'h1, "x7_slt");
        exec(32'h0002B3B3, 32'h0);                       // sltu x7,x5,x0
        rdreg(5'd7, 32'h0, "x7_sltu");

        exec(32'h00314433, 32'h0);                       // xor x8,x2,x3
        rdreg(5'd8, 32'hFFFFFFF1, "x8_xor");
        exec(32'h0020E4B3, 32'h0);                       // or x9,x1,x2
        rdreg(5'd9, 32'hF, "x9_or");
        exec(32'h0F01F513, 32'h0);                       // andi x10,x3,0xF0
        rdreg(5'd10, 32'hF0, "x10_andi");
        exec(32'h001095B3, 32'h0);                       // sll x11,x1,x1
        rdreg(5'd11, 32'hA0, "x11_sll");

        exec(32'h008000EF, 32'h100);                     // jal x1,+8
        expect_val("jal_imm", S_IMM, 32'h8);
        rdreg(5'd1, 32'h104, "x1_jal");

        exec(32'h00408167, 32'h200);                     // jalr x2,4(x1)
        expect_val("jalr_imm", S_IMM, 32'h4);
        expect_val("jalr_rs1", S_RS1, 32'h104);
        rdreg(5'd2, 32'h204, "x2_jalr");

        exec(32'hFFFFFFFF, 32'h0);
        expect_val("ones_inv", S_INV, 32'h1);
        exec(32'h00000083, 32'h0);                       // opcode 00000, rd=x1
        expect_val("opc0_inv", S_INV, 32'h1);
        rdreg(5'd1, 32'h104, "x1_kept");
        exec(32'h02108133, 32'h0);                       // add with funct7=0000001
        expect_val("f7_inv", S_INV, 32'h1);
        rdreg(5'd2, 32'h204, "x2_kept");

        insn = 32'h00900693;                             // addi x13,x0,9
        rden = 1'b1;
        @(posedge clk);
        #1 rden = 1'b0;
        @(posedge clk);
        #1 wren = 1'b1;
        rst_ni = 1'b0;
        expect_val("rstmid_alu", S_ALU, 32'h0);
        @(posedge clk);
        #1 wren = 1'b0;
        rst_ni = 1'b1;
        rdreg(5'd13, 32'h0, "x13_dropped");
        rdreg(5'd1,  32'h0, "x1_cleared");
        rdreg(5'd4,  32'h0, "x4_cleared");

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
